shift_register_univ: RTL and testbench

//  Parametrised universal shift register. Supports parallel load, clear, logical

---
 rtl/shift_register_univ.sv | 144 ++++++++++++++
 tb/tb_shift_register_univ.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/shift_register_univ.sv
// Universal shift register: load, clear, shift, rotate and arithmetic shift, with a
// multi-cycle burst mode that repeats a shift op N times and reports busy/done.
module shift_register_univ #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [2:0]         op_i,
  input  logic               start_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [WIDTH-1:0]   par_in_i,
  input  logic               sin_l_i,
  input  logic               sin_r_i,
  output logic [WIDTH-1:0]   q_o,
  output logic               sout_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [2:0] OpHold = 3'b000;
  localparam logic [2:0] OpLoad = 3'b001;
  localparam logic [2:0] OpShl  = 3'b010;
  localparam logic [2:0] OpShr  = 3'b011;
  localparam logic [2:0] OpRol  = 3'b100;
  localparam logic [2:0] OpRor  = 3'b101;
  localparam logic [2:0] OpAsr  = 3'b110;
  localparam logic [2:0] OpClr  = 3'b111;

  localparam logic StIdle  = 1'b0;
  localparam logic StShift = 1'b1;

  localparam logic [SHAMT_W-1:0] CntZero = '0;
  localparam logic [SHAMT_W-1:0] CntOne  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  logic               state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         op_lat_q, op_lat_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               sout_q, sout_d;
  logic               done_q, done_d;

  logic [2:0]       sel_op;
  logic [WIDTH-1:0] q_step;
  logic             sout_step;
  logic             op_is_shift;

  assign op_is_shift = (op_i != OpHold) && (op_i != OpLoad) && (op_i != OpClr);

  // One step of whichever op is in effect: live op when idle, latched op mid-burst.
  always_comb begin
    sel_op    = (state_q == StShift) ? op_lat_q : op_i;
    q_step    = q_q;
    sout_step = sout_q;
    case (sel_op)
      OpLoad: q_step = par_in_i;
      OpShl: begin
        q_step    = {q_q[WIDTH-2:0], sin_l_i};
        sout_step = q_q[WIDTH-1];
      end
      OpShr: begin
        q_step    = {sin_r_i, q_q[WIDTH-1:1]};
        sout_step = q_q[0];
      end
      OpRol: begin
        q_step    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        sout_step = q_q[WIDTH-1];
      end
      OpRor: begin
        q_step    = {q_q[0], q_q[WIDTH-1:1]};
        sout_step = q_q[0];
      end
      OpAsr: begin
        q_step    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        sout_step = q_q[0];
      end
      OpClr:   q_step = '0;
      default: q_step = q_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_lat_d = op_lat_q;
    q_d      = q_q;
    sout_d   = sout_q;
    done_d   = 1'b0;
    if (state_q == StIdle) begin
      if (start_i && op_is_shift) begin
        if (shamt_i == CntZero) begin
          done_d = 1'b1;
        end else begin
          q_d    = q_step;
          sout_d = sout_step;
          if (shamt_i == CntOne) begin
            done_d = 1'b1;
          end else begin
            op_lat_d = op_i;
            cnt_d    = shamt_i - CntOne;
            state_d  = StShift;
          end
        end
      end else begin
        q_d    = q_step;
        sout_d = sout_step;
      end
    end else begin
      q_d    = q_step;
      sout_d = sout_step;
      if (cnt_q == CntOne) begin
        state_d = StIdle;
        cnt_d   = CntZero;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_lat_q <= OpHold;
      q_q      <= '0;
      sout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_lat_q <= op_lat_d;
      q_q      <= q_d;
      sout_q   <= sout_d;
      done_q   <= done_d;
    end
  end

  assign q_o    = q_q;
  assign sout_o = sout_q;
  assign busy_o = (state_q == StShift);
  assign done_o = done_q;

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed plus randomized checks of shift_register_univ against an arithmetic model.
module tb_shift_register_univ;

  logic       clk = 1'b0;
  logic       rst, start, sin_l, sin_r;
  logic [2:0] op;
  logic [3:0] shamt;
  logic [7:0] par_in;
  logic [7:0] q;
  logic       sout, busy, done;

  int tests = 0;
  int fails = 0;

  // Model: register value, last-out bit, remaining burst shifts, latched op.
  int m_q, m_sout, m_rem, m_lop, m_done;

  shift_register_univ #(.WIDTH(8), .SHAMT_W(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .op_i    (op),
    .start_i (start),
    .shamt_i (shamt),
    .par_in_i(par_in),
    .sin_l_i (sin_l),
    .sin_r_i (sin_r),
    .q_o     (q),
    .sout_o  (sout),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input int o, input int sl, input int sr);
    int v;
    v = m_q;
    case (o)
      1: m_q = par_in;
      2: begin m_q = ((v * 2) + sl) % 256;         m_sout = v / 128; end
      3: begin m_q = (v / 2) + sr * 128;           m_sout = v % 2;   end
      4: begin m_q = ((v * 2) % 256) + v / 128;    m_sout = v / 128; end
      5: begin m_q = (v / 2) + (v % 2) * 128;      m_sout = v % 2;   end
      6: begin m_q = (v / 2) + (v >= 128 ? 128 : 0); m_sout = v % 2; end
      7: m_q = 0;
      default: ;
    endcase
  endtask

  task automatic step(input logic r, input logic [2:0] o, input logic s, input logic [3:0] n,
                      input logic [7:0] p, input logic sl, input logic sr);
    rst = r; op = o; start = s; shamt = n; par_in = p; sin_l = sl; sin_r = sr;
    m_done = 0;
    if (r) begin
      m_q = 0; m_sout = 0; m_rem = 0; m_lop = 0;
    end else if (m_rem > 0) begin
      model_apply(m_lop, sl, sr);
      m_rem--;
      if (m_rem == 0) m_done = 1;
    end else if (s && o >= 2 && o <= 6) begin
      if (n == 0) m_done = 1;
      else begin
        model_apply(o, sl, sr);
        if (n == 1) m_done = 1;
        else begin m_rem = n - 1; m_lop = o; end
      end
    end else begin
      model_apply(o, sl, sr);
    end
    @(posedge clk);
    #1;
    chk("q", q, m_q);
    chk("sout", sout, m_sout);
    chk("busy", busy, (m_rem > 0) ? 1 : 0);
    chk("done", done, m_done);
  endtask

  initial begin
    rst = 1'b1; op = 3'd0; start = 1'b0; shamt = 4'd0; par_in = 8'd0;
    sin_l = 1'b0; sin_r = 1'b0;
    m_q = 0; m_sout = 0; m_rem = 0; m_lop = 0; m_done = 0;

    // Reset state
    step(1, 3'd0, 0, 0, 8'h00, 0, 0);
    chk("rst_q", q, 8'h00);
    chk("rst_busy", busy, 0);

    // SHL with serial fill
    step(0, 3'd1, 0, 0, 8'hA5, 0, 0);
    step(0, 3'd2, 0, 0, 8'h00, 1, 0);
    chk("shl_q", q, 8'h4B);
    chk("shl_sout", sout, 1);

    // ROR / ROL
    step(0, 3'd1, 0, 0, 8'h81, 0, 0);
    step(0, 3'd5, 0, 0, 8'h00, 0, 0);
    chk("ror_q", q, 8'hC0);
    chk("ror_sout", sout, 1);
    step(0, 3'd1, 0, 0, 8'h81, 0, 0);
    step(0, 3'd4, 0, 0, 8'h00, 0, 0);
    chk("rol_q", q, 8'h03);
    chk("rol_sout", sout, 1);

    // ASR burst of 3, LOAD ignored while busy
    step(0, 3'd1, 0, 0, 8'h90, 0, 0);
    step(0, 3'd6, 1, 4'd3, 8'h00, 0, 0);
    chk("asr_busy1", busy, 1);
    step(0, 3'd1, 0, 0, 8'h55, 0, 0);
    chk("asr_busy2", busy, 1);
    step(0, 3'd1, 0, 0, 8'h55, 0, 0);
    chk("asr_q", q, 8'hF2);
    chk("asr_done", done, 1);
    step(0, 3'd0, 0, 0, 8'h00, 0, 0);
    chk("asr_done_pulse", done, 0);

    // Reset aborts a burst without done
    step(0, 3'd1, 0, 0, 8'hFF, 0, 0);
    step(0, 3'd2, 1, 4'd5, 8'h00, 0, 0);
    step(0, 3'd0, 0, 0, 8'h00, 0, 0);
    chk("abort_mid_q", q, 8'hFC);
    step(1, 3'd0, 0, 0, 8'h00, 0, 0);
    chk("abort_q", q, 8'h00);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 3'd0, 0, 0, 8'h00, 0, 0);
      chk("abort_no_done", done, 0);
    end

    // Zero-length burst, start with a non-shift op
    step(0, 3'd1, 0, 0, 8'h3C, 0, 0);
    step(0, 3'd4, 1, 4'd0, 8'h00, 0, 0);
    chk("zero_q", q, 8'h3C);
    chk("zero_done", done, 1);
    step(0, 3'd7, 1, 4'd4, 8'h00, 0, 0);
    chk("clr_q", q, 8'h00);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);

    // ROL by WIDTH leaves q unchanged; back-to-back burst accepted on done
    step(0, 3'd1, 0, 0, 8'h6B, 0, 0);
    step(0, 3'd4, 1, 4'd8, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 3'd0, 0, 0, 8'h00, 0, 0);
    chk("rol8_q", q, 8'h6B);
    chk("rol8_done", done, 1);
    step(0, 3'd3, 1, 4'd2, 8'h00, 1, 1);
    step(0, 3'd0, 0, 0, 8'h00, 0, 1);
    chk("b2b_done", done, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 8'($urandom),
           1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
